// File: rtl/reg_file_wdemux_if.sv
// Register-file port bundle: write port, two read ports and the registered write one-hot image.
// The datapath side (master) drives addresses/data; the register file (slave) returns read data.
interface reg_file_wdemux_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [DW-1:0]        wr_data;
   logic [AW-1:0]        rd_addr1;
   logic [AW-1:0]        rd_addr2;
   logic [DW-1:0]        rd_data1;
   logic [DW-1:0]        rd_data2;
   logic [(1<<AW)-1:0]   wr_onehot;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
      input  rd_data1, rd_data2, wr_onehot
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
      output rd_data1, rd_data2, wr_onehot
   );
endinterface

// File: rtl/reg_file_wdemux.sv
// 2^AW x DW register file, R0 hardwired to zero, one-hot write decode, two bypassing read ports.
// Reads are combinational (0 cycles), writes commit on the next edge; no backpressure, always accepts.
module reg_file_wdemux #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   reg_file_wdemux_if.slave rf
);
   localparam int NR = 1 << AW;

   logic [NR-1:0] dec;
   logic [DW-1:0] regs [NR];

   // Bit 0 stays zero so R0 can never be written or flagged as committed.
   always_comb begin
      dec = '0;
      for (int i = 1; i < NR; i++) begin
         dec[i] = rf.wr_en && (rf.wr_addr == AW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) begin
            regs[i] <= '0;
         end
         rf.wr_onehot <= '0;
      end else begin
         for (int i = 1; i < NR; i++) begin
            if (dec[i]) begin
               regs[i] <= rf.wr_data;
            end
         end
         rf.wr_onehot <= dec;
      end
   end

   always_comb begin
      rf.rd_data1 = regs[rf.rd_addr1];
      if (rf.rd_addr1 == '0) begin
         rf.rd_data1 = '0;
      end else if (rf.wr_en && (rf.wr_addr == rf.rd_addr1)) begin
         rf.rd_data1 = rf.wr_data;
      end
   end

   always_comb begin
      rf.rd_data2 = regs[rf.rd_addr2];
      if (rf.rd_addr2 == '0) begin
         rf.rd_data2 = '0;
      end else if (rf.wr_en && (rf.wr_addr == rf.rd_addr2)) begin
         rf.rd_data2 = rf.wr_data;
      end
   end
endmodule

// File: tb/tb_reg_file_wdemux.sv
// Scoreboarded bench: stimulus pushes model-predicted read/one-hot values, a negedge monitor compares.
module tb_reg_file_wdemux;
   logic clk;
   logic rst_n;

   reg_file_wdemux_if #(.DW(16), .AW(4)) rf ();

   reg_file_wdemux #(.DW(16), .AW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (rf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d1;
      logic [15:0] d2;
      logic [15:0] oh;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: plain array of register contents plus last-commit image.
   logic [15:0] mem [16];
   logic [15:0] last_oh;
   logic        cur_we;
   logic [3:0]  cur_wa;
   logic [15:0] cur_wd;

   function automatic logic [15:0] model_rd(input logic [3:0] a);
      if (a == 4'd0) return 16'h0000;
      if (cur_we && cur_wa == a) return cur_wd;
      return mem[a];
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: account for the commit at the edge, then drive the next inputs.
   task automatic step(input bit rst, input bit we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [3:0] r1, input logic [3:0] r2);
      @(posedge clk);
      last_oh = 16'h0000;
      if (rst_n && cur_we && cur_wa != 4'd0) begin
         mem[cur_wa] = cur_wd;
         last_oh[cur_wa] = 1'b1;
      end
      #1;
      rst_n = rst;
      if (!rst) begin
         for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
         last_oh = 16'h0000;
      end
      rf.wr_en    = we;
      rf.wr_addr  = wa;
      rf.wr_data  = wd;
      rf.rd_addr1 = r1;
      rf.rd_addr2 = r2;
      cur_we = we;
      cur_wa = wa;
      cur_wd = wd;
      exp_q.push_back('{d1: model_rd(r1), d2: model_rd(r2), oh: last_oh});
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data1", rf.rd_data1, e.d1);
            chk("rd_data2", rf.rd_data2, e.d2);
            chk("wr_onehot", rf.wr_onehot, e.oh);
         end
      end
   end

   initial begin : stimulus
      rst_n = 1'b0;
      rf.wr_en = 1'b0;
      rf.wr_addr = '0;
      rf.wr_data = '0;
      rf.rd_addr1 = '0;
      rf.rd_addr2 = '0;
      cur_we = 1'b0;
      cur_wa = '0;
      cur_wd = '0;
      last_oh = '0;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

      // Reset state, then release.
      step(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd9);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 4'd15);

      // R5 = BEEF, read back, then async reset clears it mid-cycle.
      step(1'b1, 1'b1, 4'd5, 16'hBEEF, 4'd1, 4'd2);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5);
      step(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5);

      // Write then read, one-hot for exactly one cycle.
      step(1'b1, 1'b1, 4'd3, 16'h1234, 4'd0, 4'd4);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd3, 4'd0);

      // Bypass on both ports over an older stored value.
      step(1'b1, 1'b1, 4'd7, 16'h00AA, 4'd0, 4'd0);
      step(1'b1, 1'b1, 4'd7, 16'h5555, 4'd7, 4'd7);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd7, 4'd7);

      // R0 immunity, including under a would-be bypass.
      step(1'b1, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd7);

      // Back-to-back writes to one register: last wins, one-hot held.
      step(1'b1, 1'b1, 4'd12, 16'h0001, 4'd12, 4'd11);
      step(1'b1, 1'b1, 4'd12, 16'h0002, 4'd12, 4'd11);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd12, 4'd11);

      // Full sweep, then read pairs (i, 16-i).
      for (int i = 1; i < 16; i++)
         step(1'b1, 1'b1, 4'(i), 16'h1000 + 16'(i), 4'(16 - i), 4'(i));
      for (int i = 1; i < 16; i++)
         step(1'b1, 1'b0, 4'd0, 16'h0, 4'(i), 4'(16 - i));

      // Reset held over an edge during a write to R9: write lost, next write commits.
      step(1'b1, 1'b1, 4'd9, 16'hCAFE, 4'd9, 4'd3);
      step(1'b0, 1'b1, 4'd9, 16'hDEAD, 4'd9, 4'd3);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd9, 4'd3);
      step(1'b1, 1'b1, 4'd9, 16'h7777, 4'd1, 4'd9);
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd9, 4'd9);

      // Randomized traffic.
      for (int n = 0; n < 400; n++)
         step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2);

      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/reg_file_wdemux.md
# reg_file_wdemux

Register file for the 16-bit processor datapath, built around a one-hot write-address decoder, the demultiplexing counterpart to the datapath's read-select muxes. One write port routes the writeback value to exactly one of sixteen 16-bit registers. Two combinational read ports include same-cycle write-to-read bypass. The block sits between the writeback stage (data-memory/ALU result select) and the decode-stage operand reads.

## Interface
- DW, 16, data width of each register and of all data ports
- AW, 4, address width; register count is 2^AW
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write enable for this cycle
- wr_addr  input  AW  destination register index
- wr_data  input  DW  writeback value
- rd_addr1  input  AW  read port 1 index
- rd_addr2  input  AW  read port 2 index
- rd_data1  output  DW  read port 1 value (combinational)
- rd_data2  output  DW  read port 2 value (combinational)
- wr_onehot  output  2^AW  registered one-hot image of the last committed write; all zero if no write was committed last cycle

## Operation
- Write decoder: combinational dec[i] = wr_en & (wr_addr == i) & (i != 0). At most one bit is set.
- Register i, for i ≥ 1, loads wr_data on the rising clk edge when dec[i] = 1 and otherwise holds its value.
- R0 is hardwired to 0:
  - Writes to index 0 are discarded.
  - dec[0] is never set.
  - Reads of index 0 always return 16'h0000, including when bypass conditions would otherwise apply.
- Read port n, for n = 1 or 2:
  - If rd_addrn == 0, return 0.
  - Else, if wr_en & (wr_addr == rd_addrn), return wr_data (bypass).
  - Else, return the stored register value.
- Both read ports are independent. They may address the same register, and either or both may bypass in the same cycle.
- wr_onehot captures dec on every rising edge, giving a one-cycle-delayed commit indicator used by hazard/debug logic.
- Reset, while rst_n = 0:
  - All registers R1..R15 are cleared to 16'h0000 asynchronously.
  - wr_onehot is cleared to 0.
  - With reset asserted, rd_data1/2 read 0 unless a bypass applies. Bypass is combinational on the wr_* inputs.
- Reset asserted mid-write: clearing takes priority and the write is lost. The first edge after rst_n deasserts may commit a write normally.
- No X propagation: every register has a defined reset value, and unused decoder outputs are tied 0.

## Timing
- Write latency: data is visible through stored state on the cycle after the edge, and through bypass in the same cycle as wr_en.
- Read latency: zero cycles, purely combinational from rd_addr, wr_en, wr_addr and wr_data.
- wr_onehot: asserted for exactly the one cycle following each committed write to a nonzero index.
- Back-to-back writes to the same register:
  - Each edge commits the current wr_data, so the last write wins.
  - wr_onehot stays high on the same bit for consecutive cycles.
- rst_n deassertion is assumed synchronized upstream to clk. No recovery logic is inside the block.

## Test plan
- Reset: assert rst_n=0 with R5 previously 16'hBEEF, then read R5 on both ports -> 16'h0000; wr_onehot -> 0.
- Write then read: wr_en=1, wr_addr=3, wr_data=16'h1234; next cycle wr_en=0, rd_addr1=3 -> rd_data1=16'h1234; wr_onehot -> 16'h0008 for one cycle, then 0.
- Bypass: R7=16'h00AA, then drive wr_en=1, wr_addr=7, wr_data=16'h5555, rd_addr1=rd_addr2=7 in the same cycle -> both ports return 16'h5555 before the edge and 16'h5555 after it.
- R0 immunity: wr_en=1, wr_addr=0, wr_data=16'hFFFF, rd_addr1=0 -> rd_data1=0 in the same cycle and the next; wr_onehot stays 0.
- Full sweep: write Ri = 16'h1000+i for i=1..15 on consecutive cycles, then read all pairs (i, 16-i) -> correct values on both ports; each write produces the matching one-hot bit exactly once.
- Reset mid-operation: pulse rst_n low between clock edges during wr_en=1, wr_addr=9 -> R9=0 after reset; the next write to R9 commits normally.
